// File: rtl/sample_queue.sv
// sample_queue
//   Producer side of the DFT sample handshake. Audio samples arrive from the
//   front end at an arbitrary rate and are held in a small circular buffer.
//   The buffer presents them, oldest first, to the operation manager. Samples
//   that arrive while the buffer is full are dropped, and a sticky flag
//   records that a drop happened.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   inSample       incoming signed sample
//   inValid        push request for inSample
//   newSample      head-of-queue sample, or 0 when the queue is empty
//   sampleReady    high while at least one sample is held
//   writeSample    one-cycle pop pulse; the consumer captures newSample on the same edge
//   count          number of samples held (0..DEPTH)
//   overflow       sticky: at least one sample has been dropped
//   clearOverflow  clears overflow; a drop in the same cycle wins

module sample_queue #(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [N-1:0]        inSample,
  input  logic                       inValid,
  output logic signed [N-1:0]        newSample,
  output logic                       sampleReady,
  input  logic                       writeSample,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clearOverflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (count == CW'(DEPTH));
  // A pop requires a held sample, so writeSample while empty is ignored.
  assign pop  = writeSample && (count != '0);
  // When full, a same-cycle pop frees the slot the push writes into. At that
  // point wrPtr equals rdPtr, but the head has already been read out during
  // this cycle, so overwriting it on the edge is safe.
  assign push = inValid && (!full || pop);
  assign drop = inValid && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= inSample;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clearOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Both outputs depend only on registered state, so they stay stable for the
  // whole cycle in which the manager pulses writeSample.
  assign sampleReady = (count != '0);
  assign newSample   = sampleReady ? mem[rdPtr] : '0;

endmodule

// File: tb/tb_sample_queue.sv
module tb_sample_queue;

  localparam int N     = 16;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [N-1:0] inSample = '0;
  logic                inValid = 1'b0;
  logic signed [N-1:0] newSample;
  logic                sampleReady;
  logic                writeSample = 1'b0;
  logic [3:0]          count;
  logic                overflow;
  logic                clearOverflow = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain queue of sample values plus the sticky flag.
  logic [N-1:0] mq[$];
  logic         movf = 1'b0;

  sample_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inSample(inSample), .inValid(inValid),
    .newSample(newSample), .sampleReady(sampleReady), .writeSample(writeSample),
    .count(count), .overflow(overflow), .clearOverflow(clearOverflow)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  // Drive one cycle of inputs, advance one edge, and update the model from
  // the queue's rules. Outputs are sampled 1 time unit after the edge.
  task automatic step(input bit iv, input logic [N-1:0] d, input bit ws,
                      input bit clr, input bit r);
    bit pop_ok, push_ok;
    inValid = iv; inSample = d; writeSample = ws; clearOverflow = clr; rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      pop_ok  = ws && (mq.size() > 0);
      push_ok = iv && ((mq.size() < DEPTH) || pop_ok);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (iv && !push_ok) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    #1;
    inValid = 0; writeSample = 0; clearOverflow = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    vectors++;
    if (count !== 4'd0 || sampleReady !== 1'b0 || newSample !== 16'sd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: count=%0d ready=%b data=%0d ovf=%b, required 0 0 0 0",
               count, sampleReady, newSample, overflow);
    end
  endtask

  task automatic test_single();
    step(1, 16'd100, 0, 0, 0);
    vectors++;
    if (count !== 4'd1 || sampleReady !== 1'b1 || newSample !== 16'sd100) begin
      miscompares++;
      $display("FAIL single_push: count=%0d ready=%b data=%0d, required 1 1 100",
               count, sampleReady, newSample);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (count !== 4'd0 || sampleReady !== 1'b0 || newSample !== 16'sd0) begin
      miscompares++;
      $display("FAIL single_pop: count=%0d ready=%b data=%0d, required 0 0 0",
               count, sampleReady, newSample);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) step(1, N'(i), 0, 0, 0);
    step(1, 16'd9, 0, 0, 0);
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: count=%0d ovf=%b, required 8 1", count, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (newSample !== N'(i) || sampleReady !== 1'b1) begin
        miscompares++;
        $display("FAIL overflow_drain[%0d]: data=%0d ready=%b, required %0d 1",
                 i, newSample, sampleReady, i);
      end
      step(0, 0, 1, 0, 0);
    end
    vectors++;
    if (count !== 4'd0 || newSample !== 16'sd0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_empty: count=%0d data=%0d ovf=%b, required 0 0 1",
               count, newSample, overflow);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_simul();
    logic [N-1:0] exp_vals [8];
    for (int i = 1; i <= 8; i++) step(1, N'(i), 0, 0, 0);
    step(1, 16'd20, 1, 0, 0);
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_simul: count=%0d ovf=%b, required 8 0", count, overflow);
    end
    for (int i = 0; i < 7; i++) exp_vals[i] = N'(i + 2);
    exp_vals[7] = 16'd20;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (newSample !== exp_vals[i]) begin
        miscompares++;
        $display("FAIL full_simul_drain[%0d]: data=%0d, required %0d",
                 i, newSample, $signed(exp_vals[i]));
      end
      step(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_wrap();
    logic signed [N-1:0] vals [5];
    vals[0] = -16'sd333; vals[1] = 16'sd222; vals[2] = 16'sd444;
    vals[3] = 16'sd555;  vals[4] = 16'sd666;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, vals[i], 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (newSample !== vals[i]) begin
          miscompares++;
          $display("FAIL wrap[%0d][%0d]: data=%0d, required %0d", r, i, newSample, vals[i]);
        end
        step(0, 0, 1, 0, 0);
      end
      vectors++;
      if (count !== 4'd0) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: count=%0d, required 0", r, count);
      end
    end
  endtask

  task automatic test_empty_pop();
    step(0, 0, 1, 0, 0);
    vectors++;
    if (count !== 4'd0 || sampleReady !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pop: count=%0d ready=%b, required 0 0", count, sampleReady);
    end
    step(1, 16'd7, 1, 0, 0);
    vectors++;
    if (count !== 4'd1 || newSample !== 16'sd7) begin
      miscompares++;
      $display("FAIL empty_push_pop: count=%0d data=%0d, required 1 7", count, newSample);
    end
    step(1, 16'd8, 0, 0, 0);
    vectors++;
    if (newSample !== 16'sd7 || count !== 4'd2) begin
      miscompares++;
      $display("FAIL empty_pop_order: data=%0d count=%0d, required 7 2", newSample, count);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_ovf_clear_and_reset();
    for (int i = 0; i < 8; i++) step(1, N'(i + 50), 0, 0, 0);
    step(1, 16'd99, 0, 0, 0);
    step(1, 16'd98, 0, 1, 0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: ovf=%b, required 1", overflow);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_lone_clear: ovf=%b, required 0", overflow);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    vectors++;
    if (count !== 4'd3 || newSample !== 16'sd55) begin
      miscompares++;
      $display("FAIL pre_reset: count=%0d data=%0d, required 3 55", count, newSample);
    end
    step(1, 16'd1, 1, 0, 1);
    vectors++;
    if (count !== 4'd0 || sampleReady !== 1'b0 || newSample !== 16'sd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d ready=%b data=%0d ovf=%b, required 0 0 0 0",
               count, sampleReady, newSample, overflow);
    end
  endtask

  task automatic test_random();
    bit iv, ws, clr, r;
    for (int c = 0; c < 600; c++) begin
      // Bias toward pushes early and pops late so both full and empty are hit.
      iv  = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ws  = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 99) == 0);
      step(iv, N'($urandom), ws, clr, r);
      vectors++;
      if (count !== 4'(mq.size()) || sampleReady !== (mq.size() > 0) ||
          newSample !== model_head() || overflow !== movf) begin
        miscompares++;
        $display("FAIL random[%0d]: count=%0d ready=%b data=%h ovf=%b, required %0d %b %h %b",
                 c, count, sampleReady, newSample, overflow,
                 mq.size(), (mq.size() > 0), model_head(), movf);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_overflow();
    test_full_simul();
    test_wrap();
    test_empty_pop();
    test_ovf_clear_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
